park_sensor_gen: RTL and testbench
==================================

// Module: park_sensor_gen
// PURPOSE
//  Transmit side of the parking-lot photo-sensor interface: turns entry/exit commands into the Pout/Pin
//  beam-break waveform a real car makes. Drives the car-count FSM in bench and on-board self-test (switch/
//  button front end issues commands). Outer beam = Pout, inner beam = Pin.
// PARAMETERS
//  DWELL_CYCLES  4   clocks each sensor phase (first/both/second) is held; >=1
//  GAP_CYCLES    2   clocks both beams clear after a passage before next command accepted; >=1
//  CNT_W         8   width of internal phase timer; must hold max(DWELL_CYCLES,GAP_CYCLES)-1
//  CAPACITY      15  lot capacity, used only with PARK_GEN_OCC_EN; <=15
// PORTS
//  Clk        in   1  clock, rising edge
//  Reset      in   1  reset, asynchronous, active-high
//  cmd_valid  in   1  command request
//  cmd_dir    in   1  0 = car enters (Pout first), 1 = car exits (Pin first)
//  cmd_ready  out  1  high only in IDLE; command accepted on edge where cmd_valid&&cmd_ready
//  Pout       out  1  outer beam broken (registered)
//  Pin        out  1  inner beam broken (registered)
//  busy       out  1  high in every state except IDLE
//  done       out  1  one-cycle pulse, first GAP cycle of a completed passage
//  Occ        out  4  [PARK_GEN_OCC_EN only] shadow occupancy
//  Reject     out  1  [PARK_GEN_OCC_EN only] one-cycle pulse, command refused
// BEHAVIOUR
//  Reset: state IDLE, Pout=Pin=0, busy=0, done=0, cmd_ready=1, timer=0, Occ=0, Reject=0.
//  FSM: IDLE -> FIRST -> BOTH -> SECOND -> GAP -> IDLE.
//   IDLE: Pout=Pin=0; on accept latch cmd_dir, load timer, go FIRST.
//   FIRST : dir0 Pout=1,Pin=0 | dir1 Pout=0,Pin=1.   BOTH: Pout=Pin=1.
//   SECOND: dir0 Pout=0,Pin=1 | dir1 Pout=1,Pin=0.   GAP : Pout=Pin=0.
//   FIRST/BOTH/SECOND each last exactly DWELL_CYCLES clocks, GAP exactly GAP_CYCLES clocks.
//  Timer counts down from N-1; advance state when timer==0, reload for next phase.
//  Latency: accept at edge k -> FIRST first visible cycle k+1; done at k+3*DWELL+1;
//   cmd_ready high again at k+3*DWELL+GAP+1.
//  Never both beams high except in BOTH; Pout/Pin change only at phase boundaries; no glitches.
//  cmd_dir sampled only at accept; changes while busy ignored. cmd_valid while busy ignored (not queued).
//  Async Reset mid-passage: outputs drop to 0 at once; partial passage abandoned, no done.
// CONFIGURATION
//  PARK_GEN_OCC_EN defined: Occ/Reject ports exist. Occ +1 at entry done, -1 at exit done.
//   Entry accepted at Occ==CAPACITY or exit at Occ==0: command consumed, no waveform,
//   Reject=1 next cycle, FSM stays IDLE, cmd_ready stays 1. Occ never wraps.
//  Not defined: no Occ/Reject ports; every accepted command produces a waveform.
// STRUCTURE
//  Package park_pkg: state encoding (IDLE..GAP, 3 bits), DIR_ENTRY=0/DIR_EXIT=1, beam-pair constants
//   for each phase per direction. Shared with the car-count FSM and its bench.
//  Sub-module park_dwell_timer: loadable down-counter (load, value, zero flag), CNT_W wide.
//  Top: FSM + registered beam decode + optional occupancy logic.
// TESTING
//  1 Entry, DWELL=4, GAP=2, accept at cyc 0 -> Pout=1 cyc1-4, both cyc5-8, Pin=1 cyc9-12, done cyc13, ready cyc15.
//  2 Exit, same params -> Pin=1 cyc1-4, both cyc5-8, Pout=1 cyc9-12; Pout/Pin never 1 outside these cycles.
//  3 cmd_valid held high, alternating cmd_dir mid-passage -> dir latched at accept, back-to-back passages separated by GAP.
//  4 Reset pulsed during BOTH -> Pout=Pin=0 same cycle, busy=0, no done; next command produces full waveform.
//  5 DWELL=1, GAP=1 -> each phase exactly 1 cycle, ready 5 cycles after accept.
//  6 [OCC_EN, CAPACITY=2] exit at Occ=0 -> Reject pulse, no beams; 3 entries -> Occ=2, third Rejected; exit -> Occ=1.

Source files
------------

// File: rtl/park_pkg.sv
// Shared encodings for the parking-lot photo-sensor interface: FSM states,
// travel direction and the Pout/Pin beam pair for each phase of a passage.
package park_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_BOTH   = 3'd2,
        S_SECOND = 3'd3,
        S_GAP    = 3'd4
    } park_state_t;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    typedef struct packed {
        logic pout;
        logic pin;
    } beam_t;

    localparam beam_t BEAM_NONE = '{pout: 1'b0, pin: 1'b0};
    localparam beam_t BEAM_OUT  = '{pout: 1'b1, pin: 1'b0};
    localparam beam_t BEAM_IN   = '{pout: 1'b0, pin: 1'b1};
    localparam beam_t BEAM_BOTH = '{pout: 1'b1, pin: 1'b1};

    // An entering car breaks the outer beam first; an exiting car the inner one.
    function automatic beam_t beam_for(park_state_t s, logic dir);
        beam_t b;
        b = BEAM_NONE;
        case (s)
            S_FIRST:  b = (dir == DIR_ENTRY) ? BEAM_OUT : BEAM_IN;
            S_BOTH:   b = BEAM_BOTH;
            S_SECOND: b = (dir == DIR_ENTRY) ? BEAM_IN : BEAM_OUT;
            default:  b = BEAM_NONE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/park_dwell_timer.sv
// Loadable down-counter that times each sensor phase; holds at zero.
module park_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            value <= '0;
        else if (load)
            value <= load_value;
        else if (!zero)
            value <= value - 1'b1;
    end

    assign zero = (value == '0);

endmodule

// File: rtl/park_sensor_gen.sv
// Turns entry/exit commands into the Pout/Pin beam-break waveform of a passing car.
// Define PARK_GEN_OCC_EN to add the shadow occupancy counter (Occ/Reject ports).
module park_sensor_gen
    import park_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 8,
    parameter int CAPACITY     = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       cmd_valid,
    input  logic       cmd_dir,
    output logic       cmd_ready,
    output logic       Pout,
    output logic       Pin,
    output logic       busy,
    output logic       done
`ifdef PARK_GEN_OCC_EN
    ,
    output logic [3:0] Occ,
    output logic       Reject
`endif
);

    if (DWELL_CYCLES < 1 || GAP_CYCLES < 1 || CAPACITY > 15 || CAPACITY < 0)
        $error("park_sensor_gen: bad parameter");

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

    park_state_t      state_q, state_nxt;
    logic             dir_q, dir_nxt;
    logic             done_nxt;
    beam_t            beam_q, beam_nxt;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_ld_val, tmr_value;
    logic             accept, refuse;

    park_dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (tmr_load),
        .load_value (tmr_ld_val),
        .value      (tmr_value),
        .zero       (tmr_zero)
    );

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt  = state_q;
        dir_nxt    = dir_q;
        tmr_load   = 1'b0;
        tmr_ld_val = DWELL_LD;
        done_nxt   = 1'b0;
        case (state_q)
            S_IDLE: if (accept && !refuse) begin
                dir_nxt   = cmd_dir;
                state_nxt = S_FIRST;
                tmr_load  = 1'b1;
            end
            S_FIRST: if (tmr_zero) begin
                state_nxt = S_BOTH;
                tmr_load  = 1'b1;
            end
            S_BOTH: if (tmr_zero) begin
                state_nxt = S_SECOND;
                tmr_load  = 1'b1;
            end
            S_SECOND: if (tmr_zero) begin
                state_nxt  = S_GAP;
                tmr_load   = 1'b1;
                tmr_ld_val = GAP_LD;
                done_nxt   = 1'b1;
            end
            S_GAP: if (tmr_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Beams come from the next state so they flip on the same edge as the FSM.
        beam_nxt = beam_for(state_nxt, dir_nxt);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_ENTRY;
            beam_q  <= BEAM_NONE;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            dir_q   <= dir_nxt;
            beam_q  <= beam_nxt;
            done    <= done_nxt;
        end
    end

    assign Pout = beam_q.pout;
    assign Pin  = beam_q.pin;

`ifdef PARK_GEN_OCC_EN
    logic [3:0] occ_q;
    logic       rej_q;

    // A refused command is consumed without a waveform; the FSM stays in IDLE.
    assign refuse = accept && ((cmd_dir == DIR_ENTRY) ? (occ_q == 4'(CAPACITY))
                                                      : (occ_q == 4'd0));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            occ_q <= 4'd0;
            rej_q <= 1'b0;
        end else begin
            rej_q <= refuse;
            if (done_nxt) begin
                if (dir_q == DIR_ENTRY && occ_q != 4'(CAPACITY))
                    occ_q <= occ_q + 4'd1;
                else if (dir_q == DIR_EXIT && occ_q != 4'd0)
                    occ_q <= occ_q - 4'd1;
            end
        end
    end

    assign Occ    = occ_q;
    assign Reject = rej_q;
`else
    assign refuse = 1'b0;
`endif

endmodule

// File: tb/tb_park_sensor_gen.sv
// Directed bench for park_sensor_gen: DWELL=4/GAP=2 main instance, DWELL=1/GAP=1 short instance.
// Build with PARK_GEN_OCC_EN to also exercise occupancy/reject (CAPACITY=2).
module tb_park_sensor_gen;

    logic Clk = 1'b0;
    logic Reset;
    logic cmd_valid, cmd_dir, cmd_ready, Pout, Pin, busy, done;
    logic v1, d1, rdy1, pout1, pin1, busy1, done1;
`ifdef PARK_GEN_OCC_EN
    logic [3:0] Occ, occ1;
    logic       Reject, rej1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    park_sensor_gen #(.DWELL_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8), .CAPACITY(2)) dut (
        .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(cmd_ready), .Pout(Pout), .Pin(Pin), .busy(busy), .done(done)
`ifdef PARK_GEN_OCC_EN
        , .Occ(Occ), .Reject(Reject)
`endif
    );

    park_sensor_gen #(.DWELL_CYCLES(1), .GAP_CYCLES(1), .CNT_W(4), .CAPACITY(15)) dut1 (
        .Clk(Clk), .Reset(Reset), .cmd_valid(v1), .cmd_dir(d1),
        .cmd_ready(rdy1), .Pout(pout1), .Pin(pin1), .busy(busy1), .done(done1)
`ifdef PARK_GEN_OCC_EN
        , .Occ(occ1), .Reject(rej1)
`endif
    );

    // Expected {Pout,Pin,busy,done,cmd_ready} j cycles after accept, DWELL=4 GAP=2.
    function automatic logic [4:0] exp_wave(int j, logic dir);
        logic a, b;
        a = (j >= 1 && j <= 8);
        b = (j >= 5 && j <= 12);
        return {dir ? b : a, dir ? a : b, (j >= 1 && j <= 14), (j == 13), (j >= 15 || j <= 0)};
    endfunction

    // Issue one command on the main instance; returns at the negedge of cycle 1.
    task automatic send(input logic dir);
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        @(posedge Clk);
        @(negedge Clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cmd_valid = 1'b0; cmd_dir = 1'b0; v1 = 1'b0; d1 = 1'b0;
        #1;
        tests++;
        if ({Pout, Pin, busy, done, cmd_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_main got=%b exp=00001", {Pout, Pin, busy, done, cmd_ready});
        end
        tests++;
        if ({pout1, pin1, busy1, done1, rdy1} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_short got=%b exp=00001", {pout1, pin1, busy1, done1, rdy1});
        end
`ifdef PARK_GEN_OCC_EN
        tests++;
        if ({Occ, Reject} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_occ got=%b exp=00000", {Occ, Reject});
        end
`endif
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_passage(input logic dir);
        send(dir);
        for (int j = 1; j <= 15; j++) begin
            tests++;
            if ({Pout, Pin, busy, done, cmd_ready} !== exp_wave(j, dir)) begin
                fails++;
                $display("FAIL passage dir=%0d cyc=%0d got=%b exp=%b", dir, j,
                         {Pout, Pin, busy, done, cmd_ready}, exp_wave(j, dir));
            end
            if (j < 15) begin
                @(posedge Clk);
                @(negedge Clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        @(posedge Clk);
        for (int j = 1; j <= 30; j++) begin
            @(negedge Clk);
            e = (j <= 15) ? exp_wave(j, 1'b0) : exp_wave(j - 15, 1'b1);
            tests++;
            if ({Pout, Pin, busy, done, cmd_ready} !== e) begin
                fails++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", j,
                         {Pout, Pin, busy, done, cmd_ready}, e);
            end
            if (j == 30)      cmd_valid = 1'b0;
            else if (j == 15) cmd_dir = 1'b1;
            else              cmd_dir = ((j % 2) == 1);
            @(posedge Clk);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        send(1'b0);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        tests++;
        if ({Pout, Pin} !== 2'b11) begin
            fails++;
            $display("FAIL reset_mid_both got=%b exp=11", {Pout, Pin});
        end
        Reset = 1'b1;
        #1;
        tests++;
        if ({Pout, Pin, busy, done, cmd_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_mid_drop got=%b exp=00001", {Pout, Pin, busy, done, cmd_ready});
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge Clk);
            tests++;
            if ({Pout, Pin, done, cmd_ready} !== 4'b0001) begin
                fails++;
                $display("FAIL reset_mid_quiet cyc=%0d got=%b exp=0001", j, {Pout, Pin, done, cmd_ready});
            end
        end
        test_passage(1'b0);
    endtask

    task automatic test_short();
        logic [4:0] tbl [1:5];
        tbl[1] = 5'b10100; tbl[2] = 5'b11100; tbl[3] = 5'b01100;
        tbl[4] = 5'b00110; tbl[5] = 5'b00001;
        @(negedge Clk);
        v1 = 1'b1;
        d1 = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        v1 = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tests++;
            if ({pout1, pin1, busy1, done1, rdy1} !== tbl[j]) begin
                fails++;
                $display("FAIL short cyc=%0d got=%b exp=%b", j, {pout1, pin1, busy1, done1, rdy1}, tbl[j]);
            end
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

`ifdef PARK_GEN_OCC_EN
    task automatic test_occ();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        send(1'b1);
        tests++;
        if ({Reject, Pout, Pin, cmd_ready, Occ} !== {4'b1001, 4'd0}) begin
            fails++;
            $display("FAIL occ_exit_empty got=%b exp=%b", {Reject, Pout, Pin, cmd_ready, Occ}, {4'b1001, 4'd0});
        end
        @(negedge Clk);
        tests++;
        if (Reject !== 1'b0) begin
            fails++;
            $display("FAIL occ_reject_pulse got=%b exp=0", Reject);
        end
        for (int n = 1; n <= 2; n++) begin
            send(1'b0);
            repeat (14) @(posedge Clk);
            @(negedge Clk);
            tests++;
            if (Occ !== 4'(n)) begin
                fails++;
                $display("FAIL occ_entry n=%0d got=%0d exp=%0d", n, Occ, n);
            end
        end
        send(1'b0);
        tests++;
        if ({Reject, Pout, Pin, cmd_ready, Occ} !== {4'b1001, 4'd2}) begin
            fails++;
            $display("FAIL occ_entry_full got=%b exp=%b", {Reject, Pout, Pin, cmd_ready, Occ}, {4'b1001, 4'd2});
        end
        send(1'b1);
        repeat (14) @(posedge Clk);
        @(negedge Clk);
        tests++;
        if (Occ !== 4'd1) begin
            fails++;
            $display("FAIL occ_exit got=%0d exp=1", Occ);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_passage(1'b0);
        test_passage(1'b1);
        test_back_to_back();
        test_reset_mid();
        test_short();
`ifdef PARK_GEN_OCC_EN
        test_occ();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
